puf_challenge_verifier: RTL

PUF_CHALLENGE_VERIFIER -- requirements
Module: puf_challenge_verifier

---
 rtl/puf_challenge_verifier.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/puf_challenge_verifier.sv
// PUF challenge/response sequencer: enrolls a table of responses, or authenticates
// fresh responses against that table by accumulated Hamming distance.
module puf_challenge_verifier #(
    parameter int unsigned N_MAX          = 16,
    parameter int unsigned HD_THRESH      = 12,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 400_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic [5:0] challenge_base,
    input  logic [3:0] num_chal,
    output logic [5:0] puf_sw,
    output logic       puf_en,
    input  logic [7:0] puf_resp,
    input  logic       puf_done,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       err,
    output logic [7:0] hd_total
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StWaitResp,
        StEval,
        StFinish
    } state_e;

    localparam logic [31:0] SettleLast  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  HdThresh    = 8'(HD_THRESH);

    state_e      state_q, state_d;
    logic        mode_q, mode_d;
    logic [5:0]  base_q, base_d;
    logic [3:0]  num_q, num_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  resp_q, resp_d;
    logic [7:0]  hd_q, hd_d;
    logic        pass_q, pass_d;
    logic        err_q, err_d;
    logic [4:0]  enr_q, enr_d;
    logic [5:0]  puf_sw_q, puf_sw_d;

    logic        tbl_we;
    logic [7:0]  tbl_rd;
    logic [7:0]  table_q [N_MAX];

    assign tbl_rd = table_q[idx_q];

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        base_d   = base_q;
        num_d    = num_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        resp_d   = resp_q;
        hd_d     = hd_q;
        pass_d   = pass_q;
        err_d    = err_q;
        enr_d    = enr_q;
        puf_sw_d = puf_sw_q;
        tbl_we   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d = mode;
                    base_d = challenge_base;
                    num_d  = num_chal;
                    idx_d  = 4'd0;
                    cnt_d  = 32'd0;
                    hd_d   = 8'd0;
                    pass_d = 1'b0;
                    err_d  = 1'b0;
                    // Authenticating more challenges than were enrolled is rejected outright.
                    if (mode && (({1'b0, num_chal} + 5'd1) > enr_q)) begin
                        err_d   = 1'b1;
                        state_d = StFinish;
                    end else begin
                        puf_sw_d = challenge_base;
                        state_d  = StSetup;
                    end
                end
            end
            StSetup: begin
                if (cnt_q == SettleLast) begin
                    cnt_d   = 32'd0;
                    state_d = StWaitResp;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StWaitResp: begin
                if (puf_done) begin
                    resp_d  = puf_resp;
                    state_d = StEval;
                end else if (cnt_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    pass_d  = 1'b0;
                    state_d = StFinish;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StEval: begin
                cnt_d = 32'd0;
                if (!mode_q) begin
                    tbl_we = 1'b1;
                end else begin
                    hd_d = hd_q + 8'($countones(resp_q ^ tbl_rd));
                end
                if (idx_q == num_q) begin
                    // Result is registered on the way into FINISH so it is valid with done.
                    pass_d  = mode_q ? (hd_d <= HdThresh) : 1'b1;
                    state_d = StFinish;
                end else begin
                    idx_d    = idx_q + 4'd1;
                    puf_sw_d = base_q + {2'b00, idx_q + 4'd1};
                    state_d  = StSetup;
                end
            end
            StFinish: begin
                if (!mode_q && !err_q) begin
                    enr_d = {1'b0, num_q} + 5'd1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            mode_q   <= 1'b0;
            base_q   <= 6'd0;
            num_q    <= 4'd0;
            idx_q    <= 4'd0;
            cnt_q    <= 32'd0;
            resp_q   <= 8'd0;
            hd_q     <= 8'd0;
            pass_q   <= 1'b0;
            err_q    <= 1'b0;
            enr_q    <= 5'd0;
            puf_sw_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            base_q   <= base_d;
            num_q    <= num_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            resp_q   <= resp_d;
            hd_q     <= hd_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            enr_q    <= enr_d;
            puf_sw_q <= puf_sw_d;
        end
    end

    // Enrollment table is deliberately not reset; enr_q = 0 guards it.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            table_q[idx_q] <= resp_q;
        end
    end

    assign puf_sw   = puf_sw_q;
    assign puf_en   = (state_q == StWaitResp);
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFinish);
    assign pass     = pass_q;
    assign err      = err_q;
    assign hd_total = hd_q;

endmodule
